gfx128_bary_div: RTL and testbench
==================================

Name: gfx128_bary_div

Overview:
Barycentric factor generator. It sits between the triangle rasterizer and the colour/UV/Z interpolator. For each raster pixel it receives two edge-function areas and the total triangle area, computes fixed-point factors f0 = e0/area and f1 = e1/area with a sequential divider, and presents them with the pixel coordinate to the interpolator. It is the producer side of the interpolator's write/ack handshake, and the consumer side of the rasterizer's handshake.

Parameters:
point_width, 16, coordinate/factor width; a factor value of 1<<point_width represents 1.0.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
write_i  in  1  rasterizer pixel valid; sampled only in IDLE
ack_o  out  1  one-cycle pulse to the rasterizer when the pixel is fully consumed downstream
x_i  in  point_width  pixel x
y_i  in  point_width  pixel y
e0_i  in  2*point_width  signed edge area for vertex 0
e1_i  in  2*point_width  signed edge area for vertex 1
area_i  in  2*point_width  signed total triangle area
write_o  out  1  one-cycle pulse to the interpolator
ack_i  in  1  interpolator acknowledge
factor0_o  out  point_width  barycentric factor 0
factor1_o  out  point_width  barycentric factor 1
x_o  out  point_width  latched x
y_o  out  point_width  latched y
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: rst_i is asynchronous, active-high; clock is clk_i. On reset, all outputs are 0 and the state is IDLE. Asserting reset mid-operation abandons the pixel and produces no ack_o.
- States:
  - IDLE: on write_i, latch x/y, |e0|, |e1|, |area|, and the sign-mismatch flags; load count = point_width; go to DIV.
  - DIV: one quotient bit per divider per cycle; stay for exactly point_width cycles; go to WRITE.
  - WRITE: register the clamped factors; write_o <= 1 for one cycle; go to WAIT_ACK.
  - WAIT_ACK: write_o <= 0; on ack_i, ack_o <= 1 for one cycle and return to IDLE.
- Latency is constant regardless of operands. If write_i is sampled at edge T, write_o is high for the cycle after edge T+point_width+1.
- write_i is ignored outside IDLE.
- ack_i is ignored outside WAIT_ACK. It is honoured in the same cycle write_o falls, at the earliest.
- ack_o is low in all states except the single cycle after ack_i is accepted.
- Division is restoring and unsigned on magnitudes:
  - remainder is 2*point_width+1 bits, initialised to |e|;
  - each step: r = 2r; if r >= |area| then r -= |area| and qbit = 1; qbits shift in MSB-first.
  - The result is floor(|e|*2^pw/|area|), truncated; no rounding.
- Clamping is applied in WRITE, in priority order:
  1. |area| == 0 -> factor = 0.
  2. sign(e) != sign(area) and e != 0 -> factor = 0, since the pixel lies outside that edge.
  3. |e| >= |area| -> factor = 2^pw-1.
  4. Otherwise the quotient.
- Both dividers run in lockstep; the divider result registers do not change outside DIV.
- x_o/y_o update in IDLE on write_i. factor*_o update only in WRITE and hold until the next WRITE.

Decomposition:
- gfx128_pkg holds:
  - the state enum bary_state_t (IDLE, DIV, WRITE, WAIT_ACK);
  - the function-style constant FACTOR_ONE = 1<<point_width.
- Sub-module gfx128_seq_div, instantiated twice:
  - Parameterised restoring divider with load/step inputs and a quotient output.
  - It has no handshake of its own; the top-level FSM drives it.

Test Plan:
- e0=1, e1=0, area=2, pw=16 -> factor0_o=0x8000, factor1_o=0x0000; write_o pulses exactly 17 cycles after the write_i sample edge.
- e0=1, e1=1, area=3 -> factor0_o=factor1_o=0x5555.
- e0=-1, e1=-2, area=-4 -> 0x4000 and 0x8000. e0=1, area=-4 -> factor0_o=0 (sign mismatch).
- e0=5, e1=7, area=5 -> factor0_o=0xFFFF, factor1_o=0xFFFF. area=0 -> both factors 0; write_o still pulses at the same latency.
- Handshake:
  - hold ack_i low 10 cycles after write_o -> stays in WAIT_ACK, busy_o=1, write_i pulses ignored;
  - then ack_i=1 -> ack_o=1 on the next cycle only, then IDLE.
- Assert rst_i at DIV cycle 8 -> all outputs 0 immediately, no write_o or ack_o; a new write_i after reset completes normally.

Source files
------------

// File: rtl/gfx128_pkg.sv
// Shared types and constants for the barycentric factor generator.
package gfx128_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV      = 2'd1,
      WRITE    = 2'd2,
      WAIT_ACK = 2'd3
   } bary_state_t;

   localparam int unsigned POINT_WIDTH = 16;

   function automatic longint unsigned factor_one(input int unsigned pw);
      return 64'd1 << pw;
   endfunction

   localparam longint unsigned FACTOR_ONE = factor_one(POINT_WIDTH);

endpackage

// File: rtl/gfx128_seq_div.sv
// Restoring unsigned divider, one quotient bit per step, quotient shifted in MSB-first.
module gfx128_seq_div #(
   parameter int unsigned W = 16
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           load_i,
   input  logic           step_i,
   input  logic [2*W-1:0] dividend_i,
   input  logic [2*W-1:0] divisor_i,
   output logic [W-1:0]   quot_o
);

   logic [2*W:0] rem_q, rem_d;
   logic [W-1:0] quot_q, quot_d;
   logic [2*W:0] rem_sh;
   logic         ge;

   always_comb begin
      rem_d  = rem_q;
      quot_d = quot_q;
      rem_sh = {rem_q[2*W-1:0], 1'b0};
      // a carry out of the shift means 2r already exceeds any divisor
      ge     = rem_q[2*W] | (rem_sh >= {1'b0, divisor_i});
      if (load_i) begin
         rem_d = {1'b0, dividend_i};
      end else if (step_i) begin
         if (ge) begin
            rem_d  = rem_sh - {1'b0, divisor_i};
            quot_d = {quot_q[W-2:0], 1'b1};
         end else begin
            rem_d  = rem_sh;
            quot_d = {quot_q[W-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rem_q  <= '0;
         quot_q <= '0;
      end else begin
         rem_q  <= rem_d;
         quot_q <= quot_d;
      end
   end

   assign quot_o = quot_q;

endmodule

// File: rtl/gfx128_bary_div.sv
// Barycentric factor generator: f0 = e0/area, f1 = e1/area in fixed point, with
// a rasterizer-side write/ack consumer and an interpolator-side write/ack producer.
//
// state    | meaning
// IDLE     | waiting for a pixel on write_i
// DIV      | dividers stepping, point_width cycles
// WRITE    | clamp and register factors, raise write_o
// WAIT_ACK | holding result until ack_i, then pulse ack_o
module gfx128_bary_div
   import gfx128_pkg::*;
#(
   parameter int unsigned point_width = POINT_WIDTH
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     write_i,
   output logic                     ack_o,
   input  logic [point_width-1:0]   x_i,
   input  logic [point_width-1:0]   y_i,
   input  logic [2*point_width-1:0] e0_i,
   input  logic [2*point_width-1:0] e1_i,
   input  logic [2*point_width-1:0] area_i,
   output logic                     write_o,
   input  logic                     ack_i,
   output logic [point_width-1:0]   factor0_o,
   output logic [point_width-1:0]   factor1_o,
   output logic [point_width-1:0]   x_o,
   output logic [point_width-1:0]   y_o,
   output logic                     busy_o
);

   localparam int unsigned PW = point_width;
   localparam int unsigned CW = $clog2(PW + 1);
   localparam logic [PW-1:0] FACTOR_MAX = PW'(factor_one(PW) - 64'd1);

   function automatic logic [2*PW-1:0] mag(input logic [2*PW-1:0] v);
      return v[2*PW-1] ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [PW-1:0] clamp(input logic mis, input logic [2*PW-1:0] e_mag,
                                           input logic [2*PW-1:0] a_mag,
                                           input logic [PW-1:0] quot);
      if (a_mag == '0)         return '0;
      else if (mis)            return '0;
      else if (e_mag >= a_mag) return FACTOR_MAX;
      else                     return quot;
   endfunction

   bary_state_t   state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] x_q, x_d, y_q, y_d;
   logic [2*PW-1:0] e0_mag_q, e0_mag_d, e1_mag_q, e1_mag_d, area_mag_q, area_mag_d;
   logic          mis0_q, mis0_d, mis1_q, mis1_d;
   logic [PW-1:0] factor0_q, factor0_d, factor1_q, factor1_d;
   logic          write_q, write_d, ack_q, ack_d;
   logic          div_load, div_step;
   logic [PW-1:0] quot0, quot1;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      x_d        = x_q;
      y_d        = y_q;
      e0_mag_d   = e0_mag_q;
      e1_mag_d   = e1_mag_q;
      area_mag_d = area_mag_q;
      mis0_d     = mis0_q;
      mis1_d     = mis1_q;
      factor0_d  = factor0_q;
      factor1_d  = factor1_q;
      write_d    = 1'b0;
      ack_d      = 1'b0;
      div_load   = 1'b0;
      div_step   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (write_i) begin
               div_load   = 1'b1;
               x_d        = x_i;
               y_d        = y_i;
               e0_mag_d   = mag(e0_i);
               e1_mag_d   = mag(e1_i);
               area_mag_d = mag(area_i);
               mis0_d     = (e0_i[2*PW-1] != area_i[2*PW-1]) && (e0_i != '0);
               mis1_d     = (e1_i[2*PW-1] != area_i[2*PW-1]) && (e1_i != '0);
               count_d    = CW'(PW);
               state_d    = DIV;
            end
         end
         DIV: begin
            div_step = 1'b1;
            count_d  = count_q - 1'b1;
            if (count_q == CW'(1)) state_d = WRITE;
         end
         WRITE: begin
            factor0_d = clamp(mis0_q, e0_mag_q, area_mag_q, quot0);
            factor1_d = clamp(mis1_q, e1_mag_q, area_mag_q, quot1);
            write_d   = 1'b1;
            state_d   = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (ack_i) begin
               ack_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         count_q    <= '0;
         x_q        <= '0;
         y_q        <= '0;
         e0_mag_q   <= '0;
         e1_mag_q   <= '0;
         area_mag_q <= '0;
         mis0_q     <= 1'b0;
         mis1_q     <= 1'b0;
         factor0_q  <= '0;
         factor1_q  <= '0;
         write_q    <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         x_q        <= x_d;
         y_q        <= y_d;
         e0_mag_q   <= e0_mag_d;
         e1_mag_q   <= e1_mag_d;
         area_mag_q <= area_mag_d;
         mis0_q     <= mis0_d;
         mis1_q     <= mis1_d;
         factor0_q  <= factor0_d;
         factor1_q  <= factor1_d;
         write_q    <= write_d;
         ack_q      <= ack_d;
      end
   end

   // divisor comes from the latched magnitude, which is stable throughout DIV
   gfx128_seq_div #(.W(PW)) u_div0 (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (div_load),
      .step_i     (div_step),
      .dividend_i (mag(e0_i)),
      .divisor_i  (area_mag_q),
      .quot_o     (quot0)
   );

   gfx128_seq_div #(.W(PW)) u_div1 (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (div_load),
      .step_i     (div_step),
      .dividend_i (mag(e1_i)),
      .divisor_i  (area_mag_q),
      .quot_o     (quot1)
   );

   assign write_o   = write_q;
   assign ack_o     = ack_q;
   assign factor0_o = factor0_q;
   assign factor1_o = factor1_q;
   assign x_o       = x_q;
   assign y_o       = y_q;
   assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_gfx128_bary_div.sv
// Self-checking bench for gfx128_bary_div: directed corner pixels, handshake
// stalls, mid-division reset and randomized pixels against an arithmetic model.
module tb_gfx128_bary_div;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        write_i, ack_o, write_o, ack_i, busy_o;
   logic [15:0] x_i, y_i, factor0_o, factor1_o, x_o, y_o;
   logic [31:0] e0_i, e1_i, area_i;

   int total = 0;
   int passed = 0;

   always #5 clk_i = ~clk_i;

   gfx128_bary_div #(.point_width(16)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .write_i   (write_i),
      .ack_o     (ack_o),
      .x_i       (x_i),
      .y_i       (y_i),
      .e0_i      (e0_i),
      .e1_i      (e1_i),
      .area_i    (area_i),
      .write_o   (write_o),
      .ack_i     (ack_i),
      .factor0_o (factor0_o),
      .factor1_o (factor1_o),
      .x_o       (x_o),
      .y_o       (y_o),
      .busy_o    (busy_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic longint model(input longint e, input longint a);
      longint em, am;
      em = (e < 0) ? -e : e;
      am = (a < 0) ? -a : a;
      if (a == 0) return 0;
      if (e != 0 && ((e < 0) != (a < 0))) return 0;
      if (em >= am) return 65535;
      return (em * 65536) / am;
   endfunction

   task automatic run_pixel(input logic signed [31:0] e0, input logic signed [31:0] e1,
                            input logic signed [31:0] area, input int ack_delay,
                            input bit poke);
      int cyc;
      logic [15:0] xe, ye;
      xe = 16'($urandom);
      ye = 16'($urandom);
      @(negedge clk_i);
      x_i = xe; y_i = ye; e0_i = e0; e1_i = e1; area_i = area;
      write_i = 1'b1;
      @(posedge clk_i); #1;
      write_i = 1'b0;
      chk("busy_after_accept", busy_o, 1);
      cyc = 0;
      while (write_o !== 1'b1 && cyc < 40) begin
         @(posedge clk_i); #1;
         cyc++;
      end
      chk("write_latency", cyc, 17);
      chk("factor0", factor0_o, model(e0, area));
      chk("factor1", factor1_o, model(e1, area));
      chk("x_o", x_o, xe);
      chk("y_o", y_o, ye);
      for (int i = 0; i < ack_delay; i++) begin
         if (poke) begin
            write_i = 1'b1;
            x_i = ~xe;
         end
         @(posedge clk_i); #1;
         if (i == 0) chk("write_pulse_one_cycle", write_o, 0);
         if (poke) chk("busy_wait_ack", busy_o, 1);
      end
      write_i = 1'b0;
      ack_i = 1'b1;
      @(posedge clk_i); #1;
      ack_i = 1'b0;
      chk("ack_pulse", ack_o, 1);
      chk("idle_after_ack", busy_o, 0);
      if (poke) chk("x_held_despite_poke", x_o, xe);
      @(posedge clk_i); #1;
      chk("ack_one_cycle", ack_o, 0);
   endtask

   initial begin
      logic signed [31:0] ra, r0, r1;
      bit seen;
      rst_i = 1'b1; write_i = 1'b0; ack_i = 1'b0;
      x_i = '0; y_i = '0; e0_i = '0; e1_i = '0; area_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("reset_outputs", {write_o, ack_o, busy_o, factor0_o, factor1_o, x_o, y_o}, 0);
      rst_i = 1'b0;

      run_pixel(1, 0, 2, 0, 0);
      chk("half_exact", factor0_o, 16'h8000);
      run_pixel(1, 1, 3, 1, 0);
      chk("third_exact", factor1_o, 16'h5555);
      run_pixel(-1, -2, -4, 2, 0);
      chk("neg_quarter", factor0_o, 16'h4000);
      run_pixel(1, -2, -4, 1, 0);
      chk("sign_mismatch", factor0_o, 16'h0000);
      run_pixel(5, 7, 5, 10, 1);
      chk("clamp_max", {factor0_o, factor1_o}, 32'hFFFF_FFFF);
      run_pixel(3, 4, 0, 0, 0);
      run_pixel(32'sh8000_0000, 0, 32'sh8000_0000, 0, 0);

      // abandon a pixel partway through division
      @(negedge clk_i);
      e0_i = 1; e1_i = 1; area_i = 3; write_i = 1'b1;
      @(posedge clk_i); #1;
      write_i = 1'b0;
      repeat (8) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      #1;
      chk("reset_mid_div", {write_o, ack_o, busy_o, factor0_o, factor1_o, x_o, y_o}, 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      seen = 1'b0;
      repeat (25) begin
         @(posedge clk_i); #1;
         if (write_o === 1'b1 || ack_o === 1'b1 || busy_o === 1'b1) seen = 1'b1;
      end
      chk("no_output_after_reset", seen, 0);
      run_pixel(1, 3, 4, 1, 0);

      for (int n = 0; n < 24; n++) begin
         if (n < 16) begin
            ra = 32'(int'($urandom_range(0, 4000)) - 2000);
            r0 = 32'(int'($urandom_range(0, 5000)) - 2500);
            r1 = 32'(int'($urandom_range(0, 5000)) - 2500);
         end else begin
            ra = 32'($urandom);
            r0 = 32'($urandom) >>> 1;
            r1 = 32'($urandom);
         end
         run_pixel(r0, r1, ra, int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
